unigate_cfg_loader: RTL

Wishbone classic slave between the Caravel management bus and the `unigate` core's serial configuration chain. It buffers 32-bit configuration words written by firmware in a small FIFO. A shift engine serializes each word, LSB first, onto the core's chain, then pulses a latch strobe on request. Completion and overflow events are reported on the user IRQ lines.

---
 rtl/unigate_cfg_loader_if.sv | 25 ++
 rtl/unigate_cfg_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/unigate_cfg_loader_if.sv
// unigate_cfg_loader_if
//   Wishbone classic bus bundle between the Caravel management SoC and
//   unigate_cfg_loader. Signal names keep the slave-side _i/_o suffixes.
//   master modport: drives cyc/stb/we/sel/adr/dat_i, receives ack/dat_o.
//   slave  modport: the reverse.
interface unigate_cfg_loader_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/unigate_cfg_loader.sv
// unigate_cfg_loader
//   Wishbone classic slave that queues 32-bit configuration words in a FIFO
//   and shifts each one LSB first into the unigate core's config chain, with
//   an optional latch strobe once the queue drains.
//
//   Optional feature macro: UNIGATE_CFG_IRQ_EN (adds IRQ_EN / IRQ_STAT and
//   drives irq_o[1:0]; otherwise irq_o is tied low).
//
// Ports
//   wb_clk_i     clock
//   wb_rst_ni    asynchronous active-low reset
//   wbs          Wishbone slave bundle (unigate_cfg_loader_if.slave)
//   cfg_shift_o  chain shift enable, one bit per cycle
//   cfg_data_o   chain serial data (valid with cfg_shift_o)
//   cfg_latch_o  single-cycle latch strobe
//   irq_o        [0] done, [1] overflow, [2] tied 0
//
// Register map (byte offset): 0x00 CTRL, 0x04 STATUS, 0x08 DATA,
//   0x0C IRQ_EN, 0x10 IRQ_STAT.
module unigate_cfg_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    unigate_cfg_loader_if.slave    wbs,
    output logic                   cfg_shift_o,
    output logic                   cfg_data_o,
    output logic                   cfg_latch_o,
    output logic [2:0]             irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [5:0] OFF_CTRL   = 6'h00;
    localparam logic [5:0] OFF_STATUS = 6'h01;
    localparam logic [5:0] OFF_DATA   = 6'h02;
`ifdef UNIGATE_CFG_IRQ_EN
    localparam logic [5:0] OFF_IEN    = 6'h03;
    localparam logic [5:0] OFF_ISTAT  = 6'h04;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;

    state_e          state_q, state_d;
    logic [31:0]     sr_q;
    logic [4:0]      cnt_q;
    logic            run_q, lpend_q, ovf_q;
    logic [15:0]     wcnt_q;
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [LW-1:0]   level_q;
    logic [31:0]     mem_q [FIFO_DEPTH];
    logic            ack_q;
    logic [31:0]     rdat_q, rdata;

    // ---------------- bus decode ----------------
    logic       hit, acc, req, wr, wr_ctrl, flush, lreq, push_req, push_ok;
    logic [5:0] off;
    logic       unused_ok;

    assign hit       = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign acc       = wbs.wbs_cyc_i & wbs.wbs_stb_i & hit;
    assign req       = acc & ~ack_q;
    // Writes commit on the edge that closes the ack cycle.
    assign wr        = acc & ack_q & wbs.wbs_we_i;
    assign off       = wbs.wbs_adr_i[7:2];
    assign wr_ctrl   = wr & (off == OFF_CTRL) & wbs.wbs_sel_i[0];
    assign flush     = wr_ctrl & wbs.wbs_dat_i[2];
    assign lreq      = wr_ctrl & wbs.wbs_dat_i[1];
    assign push_req  = wr & (off == OFF_DATA) & (wbs.wbs_sel_i == 4'hF);
    assign unused_ok = &{1'b0, wbs.wbs_adr_i[1:0]};

    // ---------------- FIFO status ----------------
    logic empty, full, pop, done_evt, ovf_evt;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(FIFO_DEPTH));
    // A push that coincides with a pop is accepted even when full.
    assign push_ok = push_req & (~full | pop);
    assign ovf_evt = push_req & full & ~pop;

    // ---------------- FSM ----------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        done_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_q && !empty) begin
                    pop     = 1'b1;
                    state_d = SHIFT;
                end else if (lpend_q && empty) begin
                    state_d = LATCH;
                end
            end
            SHIFT: begin
                if (cnt_q == 5'd31) begin
                    // Chain the next word with no idle bubble.
                    if (run_q && !empty) pop = 1'b1;
                    else                 state_d = IDLE;
                end
            end
            LATCH: begin
                done_evt = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Decoded straight from the state register so reset drops them at once.
    assign cfg_shift_o = (state_q == SHIFT);
    assign cfg_data_o  = (state_q == SHIFT) & sr_q[0];
    assign cfg_latch_o = (state_q == LATCH);

    // ---------------- shift engine / control ----------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            run_q   <= 1'b0;
            lpend_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (pop) begin
                sr_q  <= mem_q[rptr_q];
                cnt_q <= '0;
            end else if (state_q == SHIFT) begin
                sr_q  <= sr_q >> 1;
                cnt_q <= cnt_q + 5'd1;
            end

            if (flush)                                     wcnt_q <= '0;
            else if (state_q == SHIFT && cnt_q == 5'd31)   wcnt_q <= wcnt_q + 16'd1;

            if (wr_ctrl) run_q <= wbs.wbs_dat_i[0];

            // A new request beats the clear from a concurrent LATCH.
            if (lreq)          lpend_q <= 1'b1;
            else if (done_evt) lpend_q <= 1'b0;

`ifdef UNIGATE_CFG_IRQ_EN
            if (ovf_evt)                                         ovf_q <= 1'b1;
            else if (wr && off == OFF_ISTAT && wbs.wbs_dat_i[1]) ovf_q <= 1'b0;
`else
            if (ovf_evt)    ovf_q <= 1'b1;
            else if (flush) ovf_q <= 1'b0;
`endif
        end
    end

    // ---------------- FIFO ----------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop)     rptr_q <= rptr_q + AW'(1);
            level_q <= level_q + LW'(push_ok) - LW'(pop);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) mem_q[wptr_q] <= wbs.wbs_dat_i;
    end

    // ---------------- interrupts ----------------
`ifdef UNIGATE_CFG_IRQ_EN
    logic [1:0] en_q, stat_q, irq_q, w1c;

    assign w1c = (wr && off == OFF_ISTAT) ? wbs.wbs_dat_i[1:0] : 2'b00;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            en_q   <= '0;
            stat_q <= '0;
            irq_q  <= '0;
        end else begin
            if (wr && off == OFF_IEN && wbs.wbs_sel_i[0]) en_q <= wbs.wbs_dat_i[1:0];
            // Set events win over a same-cycle W1C.
            stat_q <= (stat_q & ~w1c) | {ovf_evt, done_evt};
            irq_q  <= stat_q & en_q;
        end
    end

    assign irq_o = {1'b0, irq_q};
`else
    assign irq_o = 3'b000;
`endif

    // ---------------- read path ----------------
    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL:   rdata[0] = run_q;
            OFF_STATUS: begin
                rdata[0]     = (state_q != IDLE);
                rdata[1]     = empty;
                rdata[2]     = full;
                rdata[3]     = ovf_q;
                rdata[10:8]  = 3'(level_q);
                rdata[31:16] = wcnt_q;
            end
`ifdef UNIGATE_CFG_IRQ_EN
            OFF_IEN:    rdata[1:0] = en_q;
            OFF_ISTAT:  rdata[1:0] = stat_q;
`endif
            default:    rdata = '0;
        endcase
    end

    // Read data is captured with the request and cleared after the ack cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q  <= 1'b0;
            rdat_q <= '0;
        end else begin
            ack_q  <= req;
            rdat_q <= (req && !wbs.wbs_we_i) ? rdata : 32'h0;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = rdat_q;
endmodule
